// File: rtl/uart_pkg.sv
// Shared state encoding and line constants for the UART transmit path.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: Bit_Done pulses on the last cycle of every CLKS_PER_BIT window after Clear drops.
// No backpressure; Clear holds the count at zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Clear,
  output logic Bit_Done
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      baud_cnt <= '0;
    end else if (Clear || baud_cnt == LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign Bit_Done = !Clear && (baud_cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART TX serialiser on the FIFO read side: pop in cycle N, start bit on Tx from N+2, LSB first.
// Pops only when idle and FIFO non-empty; optional parity bit under UART_TX_PARITY_EN.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Fifo_Empty,
  output logic       Fifo_Read,
  input  logic [7:0] Fifo_Dout,
`ifdef UART_TX_PARITY_EN
  input  logic       Parity_Odd,
`endif
  output logic       Tx,
  output logic       Busy
);

  localparam logic [2:0] DATA_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_t  state;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx;
  logic       armed;
  logic       bit_done;
  logic       baud_clear;
`ifdef UART_TX_PARITY_EN
  logic       parity_bit;
`endif

  // armed keeps the pop strobe low while reset is held and for the release cycle
  assign Fifo_Read  = (state == IDLE) && armed && !Fifo_Empty;
  assign Busy       = (state != IDLE) || Fifo_Read;
  assign baud_clear = (state == IDLE) || (state == LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clear   (baud_clear),
    .Bit_Done(bit_done)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      Tx         <= UART_IDLE_LEVEL;
      shift_reg  <= '0;
      bit_idx    <= '0;
      armed      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (Fifo_Read) state <= LOAD;
        end
        LOAD: begin
          shift_reg  <= Fifo_Dout;
          bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
          parity_bit <= (^Fifo_Dout) ^ Parity_Odd;
`endif
          Tx         <= 1'b0;
          state      <= START;
        end
        START: begin
          if (bit_done) begin
            Tx    <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              Tx      <= parity_bit;
              state   <= PARITY;
`else
              Tx      <= UART_IDLE_LEVEL;
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              Tx      <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            Tx    <= UART_IDLE_LEVEL;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboarded bench for uart_tx_serializer: a FIFO model feeds bytes, a monitor checks every Tx cycle.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int HDR_BITS = 10;  // start + data + parity
`else
  localparam int HDR_BITS = 9;   // start + data
`endif

  typedef struct {
    logic [15:0] bits;
    int          nbits;
  } frame_t;

  logic       Clk        = 1'b0;
  logic       Reset_n    = 1'b0;
  logic       Fifo_Empty = 1'b1;
  logic       Fifo_Read;
  logic [7:0] Fifo_Dout  = 8'h00;
  logic       Parity_Odd = 1'b0;
  logic       Tx;
  logic       Busy;

  logic       Fifo_Empty2 = 1'b1;
  logic       Fifo_Read2;
  logic [7:0] Fifo_Dout2  = 8'h00;
  logic       Parity_Odd2 = 1'b0;
  logic       Tx2;
  logic       Busy2;

  int         errors      = 0;
  int         checks      = 0;
  int         frames_done = 0;
  int         viol        = 0;
  logic       hold_empty  = 1'b0;
  logic [7:0] fifo_q[$];
  frame_t     exp_q[$];

  always #5 Clk = ~Clk;

  uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Fifo_Empty(Fifo_Empty),
    .Fifo_Read (Fifo_Read),
    .Fifo_Dout (Fifo_Dout),
`ifdef UART_TX_PARITY_EN
    .Parity_Odd(Parity_Odd),
`endif
    .Tx        (Tx),
    .Busy      (Busy)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Fifo_Empty(Fifo_Empty2),
    .Fifo_Read (Fifo_Read2),
    .Fifo_Dout (Fifo_Dout2),
`ifdef UART_TX_PARITY_EN
    .Parity_Odd(Parity_Odd2),
`endif
    .Tx        (Tx2),
    .Busy      (Busy2)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic frame_t build_frame(input logic [7:0] b, input logic odd);
    frame_t f;
    f.bits      = '1;
    f.bits[0]   = 1'b0;
    f.bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f.bits[9]   = (^b) ^ odd;
    f.nbits     = 11;
`else
    f.nbits     = 10;
    if (odd) f.nbits = 10;
`endif
    return f;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(posedge Clk);
    #1;
    fifo_q.push_back(b);
    exp_q.push_back(build_frame(b, Parity_Odd));
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 500) begin
      @(negedge Clk);
      n++;
    end
    check_val("frames_done", frames_done, target);
  endtask

  // FIFO model: registered read data and a registered empty flag
  always @(posedge Clk) begin
    if (Fifo_Read && fifo_q.size() > 0) Fifo_Dout <= fifo_q.pop_front();
    Fifo_Empty <= hold_empty || (fifo_q.size() == 0);
  end

  always @(negedge Clk) begin
    if (Fifo_Read && Fifo_Empty) viol++;
  end

  initial begin : monitor
    frame_t f;
    logic   abort;
    logic   expect_pop;
    logic   expect_idle;
    expect_pop  = 1'b0;
    expect_idle = 1'b0;
    forever begin
      @(negedge Clk);
      if (expect_pop) begin
        check_val("b2b_pop", Fifo_Read, 1);
        check_val("b2b_gap_tx", Tx, 1);
      end
      if (expect_idle) check_val("idle_after_stop", Busy, 0);
      expect_pop  = 1'b0;
      expect_idle = 1'b0;
      if (Reset_n && Fifo_Read) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_pop", 1, 0);
        end else begin
          f     = exp_q.pop_front();
          abort = 1'b0;
          check_val("busy_at_pop", Busy, 1);
          @(negedge Clk);
          if (!Reset_n) abort = 1'b1;
          else begin
            check_val("load_tx_high", Tx, 1);
            check_val("load_no_pop", Fifo_Read, 0);
          end
          for (int i = 0; i < f.nbits && !abort; i++) begin
            for (int k = 0; k < C && !abort; k++) begin
              @(negedge Clk);
              if (!Reset_n) abort = 1'b1;
              else begin
                check_val($sformatf("frame_bit%0d", i), Tx, f.bits[i]);
                check_val("busy_in_frame", Busy, 1);
                check_val("no_pop_in_frame", Fifo_Read, 0);
              end
            end
          end
          if (!abort) begin
            frames_done++;
            if (fifo_q.size() > 0 && !hold_empty) expect_pop = 1'b1;
            else expect_idle = 1'b1;
          end
        end
      end
    end
  end

  initial begin : stim
    int     tgt;
    int     n;
    int     bad;
    int     len;
    int     stop_hi;
    logic   tx2_log[64];
    logic   busy2_log[64];
    frame_t e2;
    tgt = 0;

    // reset held with data available: outputs stay quiet
    push_byte(8'h5A); tgt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check_val("rst_tx", Tx, 1);
      check_val("rst_read", Fifo_Read, 0);
      check_val("rst_busy", Busy, 0);
    end
    @(posedge Clk); #1; Reset_n = 1'b1;
    wait_frames(tgt);

    push_byte(8'hA5); tgt++;
    wait_frames(tgt);

`ifdef UART_TX_PARITY_EN
    Parity_Odd = 1'b0;
    push_byte(8'hA5); tgt++;
    wait_frames(tgt);
    Parity_Odd = 1'b1;
    push_byte(8'hA5); tgt++;
    wait_frames(tgt);
    Parity_Odd = 1'b0;
`endif

    push_byte(8'h00); tgt++;
    push_byte(8'hFF); tgt++;
    wait_frames(tgt);

    // empty flag held: no pop for 100 cycles even with a byte queued
    hold_empty = 1'b1;
    push_byte(8'h55); tgt++;
    @(posedge Clk); #1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Fifo_Read !== 1'b0 || Tx !== 1'b1 || Busy !== 1'b0) bad++;
    end
    check_val("empty_hold_quiet", bad, 0);
    hold_empty = 1'b0;
    wait_frames(tgt);

    // reset in the middle of the data bits
    push_byte(8'h3C);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Fifo_Read && n < 50);
    check_val("mid_pop_seen", Fifo_Read, 1);
    repeat (10) @(posedge Clk);
    #1;
    check_val("mid_data_tx", Tx, 0);
    Reset_n = 1'b0;
    #1;
    check_val("mid_rst_tx", Tx, 1);
    check_val("mid_rst_busy", Busy, 0);
    check_val("mid_rst_read", Fifo_Read, 0);
    hold_empty = 1'b1;
    push_byte(8'h99); tgt++;
    repeat (3) @(posedge Clk);
    #1; Reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Fifo_Read !== 1'b0 || Busy !== 1'b0) bad++;
    end
    check_val("post_rst_no_pop", bad, 0);
    hold_empty = 1'b0;
    wait_frames(tgt);

    // two stop bits on the second instance
    @(posedge Clk); #1; Fifo_Empty2 = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Fifo_Read2 && n < 20);
    check_val("s2_pop", Fifo_Read2, 1);
    @(posedge Clk); #1;
    Fifo_Empty2 = 1'b1;
    Fifo_Dout2  = 8'h81;
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      tx2_log[i]   = Tx2;
      busy2_log[i] = Busy2;
    end
    check_val("s2_load_tx", tx2_log[0], 1);
    e2 = build_frame(8'h81, 1'b0);
    for (int i = 0; i < HDR_BITS; i++) begin
      bad = 0;
      for (int k = 0; k < C; k++) if (tx2_log[1 + i*C + k] !== e2.bits[i]) bad++;
      check_val($sformatf("s2_bit%0d", i), bad, 0);
    end
    len = 0;
    while (len < 63 && busy2_log[1 + len]) len++;
    check_val("s2_frame_len", len, (HDR_BITS + 2) * C);
    stop_hi = 0;
    for (int i = 1 + HDR_BITS*C; i < 1 + len && i < 64; i++) if (tx2_log[i]) stop_hi++;
    check_val("s2_stop_high", stop_hi, 2 * C);

    check_val("read_while_empty", viol, 0);
    check_val("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
